data_mem_responder: RTL and testbench

Single-port, word-organised data memory that answers load/store requests issued by the CPU memory stage. It accepts one request at a time over a req/ack handshake and inserts a configurable number of wait states. It performs byte-lane-masked writes and full-word reads. It drives a busy flag that the pipeline uses as its memory-stage stall. It sits between the memory stage and the on-chip data RAM, acting as the responder end of the load/store interface.

---
 rtl/data_mem_responder.sv | 121 ++++++++++++
 tb/tb_data_mem_responder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Load/store responder for the CPU memory stage: req/ack handshake, fixed wait
// states, byte-lane masked word writes, out-of-range error reporting.
module data_mem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [29:0] addr_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int         DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [29:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        cap, acc;
  logic        acc_we;
  logic [29:0] acc_addr;
  logic [3:0]  acc_be;
  logic [31:0] acc_wdata;
  logic        in_range;

  logic [31:0] mem [DEPTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    acc     = 1'b0;
    case (state_q)
      S_IDLE: if (req_i) begin
        cap = 1'b1;
        if (WAIT_STATES == 0) begin
          acc     = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d   = WS_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: if (cnt_q == 4'd0) begin
        acc     = 1'b1;
        state_d = S_RESP;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states the access happens on the accepting edge, so the
  // live request fields are used instead of the captured copies.
  assign acc_we    = cap ? we_i    : we_q;
  assign acc_addr  = cap ? addr_i  : addr_q;
  assign acc_be    = cap ? be_i    : be_q;
  assign acc_wdata = cap ? wdata_i : wdata_q;
  assign in_range  = (acc_addr >> DEPTH_LOG2) == '0;

  always_comb begin
    err_d   = acc ? ~in_range : err_q;
    rdata_d = rdata_q;
    if (acc && !acc_we)
      rdata_d = in_range ? mem[acc_addr[DEPTH_LOG2-1:0]] : 32'h0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (cap) begin
        we_q    <= we_i;
        addr_q  <= addr_i;
        be_q    <= be_i;
        wdata_q <= wdata_i;
      end
    end
  end

  // Memory array carries no reset so it can map onto a RAM macro.
  always_ff @(posedge clk_i) begin
    if (!rst_i && acc && acc_we && in_range)
      for (int i = 0; i < 4; i++)
        if (acc_be[i]) mem[acc_addr[DEPTH_LOG2-1:0]][8*i +: 8] <= acc_wdata[8*i +: 8];
  end

  assign ack_o   = (state_q == S_RESP);
  assign err_o   = ack_o & err_q;
  assign rdata_o = rdata_q;
  assign busy_o  = req_i & ~ack_o;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: four responders (wait states 1, 0, 3, 15) sharing request
// fields, each with its own req line; table vectors plus handshake corner cases.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic        we;
  logic [29:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [3:0]  ack, err, busy;
  logic [31:0] rdata [4];

  int cyc = 0;
  int chk_cnt = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ws_of(input int k);
    case (k)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 15;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    data_mem_responder #(
      .DEPTH_LOG2 (10),
      .WAIT_STATES(g == 0 ? 1 : g == 1 ? 0 : g == 2 ? 3 : 15)
    ) u_dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .req_i  (req[g]),
      .we_i   (we),
      .addr_i (addr),
      .be_i   (be),
      .wdata_i(wdata),
      .ack_o  (ack[g]),
      .rdata_o(rdata[g]),
      .err_o  (err[g]),
      .busy_o (busy[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // One handshake on instance k. Latency counts clock edges from the cycle in
  // which req is first presented up to the ack cycle; -1 means no ack seen.
  task automatic xact(input int k, input bit b2b, input logic w, input logic [29:0] a,
                      input logic [3:0] b, input logic [31:0] d,
                      output int lat, output int bcnt, output logic [31:0] rd,
                      output logic e, output int t_ack);
    if (!b2b) @(posedge clk);
    @(negedge clk);
    we = w; addr = a; be = b; wdata = d; req[k] = 1'b1;
    #1;
    lat  = 0;
    bcnt = int'(busy[k]);
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      bcnt += int'(busy[k]);
      if (ack[k]) break;
    end
    if (!ack[k]) lat = -1;
    rd     = rdata[k];
    e      = err[k];
    t_ack  = cyc;
    req[k] = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat, bcnt, t1, t2, acks;
    logic [31:0] rd;
    logic e;

    // rdata expectation on stores is the last load value: stores must not touch it
    vecs[0] = '{1'b1, 30'd5,     4'hF, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[1] = '{1'b0, 30'd5,     4'h0, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 30'd7,     4'hF, 32'h11223344, 32'hDEADBEEF, 1'b0};
    vecs[3] = '{1'b1, 30'd7,     4'h5, 32'hAABBCCDD, 32'hDEADBEEF, 1'b0};
    vecs[4] = '{1'b0, 30'd7,     4'h0, 32'h0,        32'h11BB33DD, 1'b0};
    vecs[5] = '{1'b1, 30'd7,     4'h0, 32'hFFFFFFFF, 32'h11BB33DD, 1'b0};
    vecs[6] = '{1'b0, 30'd7,     4'h0, 32'h0,        32'h11BB33DD, 1'b0};
    vecs[7] = '{1'b0, 30'h400,   4'h0, 32'h0,        32'h00000000, 1'b1};
    vecs[8] = '{1'b1, 30'h405,   4'hF, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[9] = '{1'b0, 30'd5,     4'h0, 32'h0,        32'hDEADBEEF, 1'b0};

    rst = 1'b1; req = 4'b0001; we = 1'b1; addr = '0; be = 4'h0; wdata = '0;

    // Reset held two cycles with req asserted
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_ack",   {31'b0, ack[0]}, 32'd0);
      chk("rst_err",   {31'b0, err[0]}, 32'd0);
      chk("rst_rdata", rdata[0],        32'd0);
      chk("rst_busy",  {31'b0, busy[0]}, 32'd1);
    end
    @(negedge clk);
    rst = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (ack[0]) break;
    end
    if (!ack[0]) lat = -1;
    req[0] = 1'b0;
    chk("rst_first_ack_lat", lat, 32'd2);

    // Table vectors on the WAIT_STATES=1 instance
    for (int i = 0; i < 10; i++) begin
      xact(0, 1'b0, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, lat, bcnt, rd, e, t1);
      chk($sformatf("vec%0d_lat", i),   lat,          32'd2);
      chk($sformatf("vec%0d_busy", i),  bcnt,         32'd2);
      chk($sformatf("vec%0d_err", i),   {31'b0, e},   {31'b0, vecs[i].exp_err});
      chk($sformatf("vec%0d_rdata", i), rd,           vecs[i].exp_rd);
    end

    // Wait-state sweep with back-to-back spacing
    for (int k = 1; k < 4; k++) begin
      xact(k, 1'b0, 1'b1, 30'd3, 4'hF, 32'hA5A50000 + k, lat, bcnt, rd, e, t1);
      chk($sformatf("sweep%0d_st_lat", k),  lat,  ws_of(k) + 1);
      chk($sformatf("sweep%0d_st_busy", k), bcnt, ws_of(k) + 1);
      xact(k, 1'b1, 1'b0, 30'd3, 4'h0, 32'h0, lat, bcnt, rd, e, t2);
      chk($sformatf("sweep%0d_b2b_lat", k),  lat,     ws_of(k) + 2);
      chk($sformatf("sweep%0d_b2b_busy", k), bcnt,    ws_of(k) + 1);
      chk($sformatf("sweep%0d_spacing", k),  t2 - t1, ws_of(k) + 2);
      chk($sformatf("sweep%0d_rdata", k),    rd,      32'hA5A50000 + k);
    end

    // Reset in the second WAIT cycle of a store on the WAIT_STATES=3 instance
    xact(2, 1'b0, 1'b1, 30'd9, 4'hF, 32'h12345678, lat, bcnt, rd, e, t1);
    chk("midrst_pre_lat", lat, 32'd4);
    @(posedge clk);
    @(negedge clk);
    we = 1'b1; addr = 30'd9; be = 4'hF; wdata = 32'hCAFEF00D; req[2] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1; req[2] = 1'b0;
    acks = 0;
    repeat (2) begin @(posedge clk); #1; acks += int'(ack[2]); end
    rst = 1'b0;
    repeat (6) begin @(posedge clk); #1; acks += int'(ack[2]); end
    chk("midrst_no_ack", acks, 32'd0);
    xact(2, 1'b0, 1'b0, 30'd9, 4'h0, 32'h0, lat, bcnt, rd, e, t1);
    chk("midrst_load_lat", lat, 32'd4);
    chk("midrst_mem9", rd, 32'h12345678);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
